// File: rtl/adder_share_ctrl_pkg.sv
// Shared types for the adder-sharing controller: FSM state codes and a
// one-hot helper used to form the grant vector.
package adder_share_pkg;

  localparam int STATE_W  = 2;
  localparam int MAX_NREQ = 8;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    EXEC  = 2'b10,
    RESP  = 2'b11
  } state_e;

  function automatic logic [MAX_NREQ-1:0] onehot(input int idx, input int nreq);
    logic [MAX_NREQ-1:0] v;
    v = '0;
    if (idx >= 0 && idx < nreq) v = MAX_NREQ'(1) << idx;
    return v;
  endfunction

endpackage

// File: rtl/adder_share_ctrl_if.sv
// Requester/response bundle between the requester blocks (master side) and
// the adder-sharing controller (slave side).
interface adder_share_ctrl_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       gnt;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_sum;
  logic                  rsp_carry;
  logic                  rsp_sovf;
  logic                  busy;

  modport master (
    output req, req_a, req_b, rsp_ready,
    input  gnt, rsp_valid, rsp_id, rsp_sum, rsp_carry, rsp_sovf, busy
  );

  modport slave (
    input  req, req_a, req_b, rsp_ready,
    output gnt, rsp_valid, rsp_id, rsp_sum, rsp_carry, rsp_sovf, busy
  );

endinterface

// File: rtl/adder_share_ctrl_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above the
// pointer, wrapping modulo NREQ.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic            any_o,
  output logic [IDW-1:0]  win_o
);

  always_comb begin
    int idx;
    idx   = 0;
    any_o = 1'b0;
    win_o = '0;
    // Scan from the farthest offset down so the nearest requester wins last.
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(ptr_i) + k) % NREQ;
      if (req_i[idx]) begin
        any_o = 1'b1;
        win_o = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/adder_share_ctrl.sv
// Round-robin sequencer sharing one registered adder among NREQ requesters:
// grant, operand capture, add, then a held response with carry/overflow.
module adder_share_ctrl
  import adder_share_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4
) (
  input logic               clk,
  input logic               rst_n,
  adder_share_ctrl_if.slave bus
);

  localparam int IDW = $clog2(NREQ);

  state_e           state_q;
  logic [NREQ-1:0]  gnt_q;
  logic [IDW-1:0]   win_id_q;
  logic [IDW-1:0]   ptr_q;
  logic [WIDTH-1:0] op_a_q;
  logic [WIDTH-1:0] op_b_q;
  logic             rsp_valid_q;
  logic [IDW-1:0]   rsp_id_q;
  logic [WIDTH-1:0] rsp_sum_q;
  logic             rsp_carry_q;
  logic             rsp_sovf_q;

  logic             any_d;
  logic [IDW-1:0]   win_d;
  logic [NREQ-1:0]  gnt_d;
  logic [IDW-1:0]   ptr_d;
  logic [WIDTH-1:0] sel_a_d;
  logic [WIDTH-1:0] sel_b_d;
  logic [WIDTH:0]   sum_full_d;

  function automatic logic signed_ovf(input logic [WIDTH-1:0] a,
                                      input logic [WIDTH-1:0] b,
                                      input logic [WIDTH-1:0] s);
    return (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
  endfunction

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req_i (bus.req),
    .ptr_i (ptr_q),
    .any_o (any_d),
    .win_o (win_d)
  );

  assign gnt_d      = NREQ'(onehot(int'(win_d), NREQ));
  assign ptr_d      = (win_id_q == IDW'(NREQ - 1)) ? '0 : win_id_q + IDW'(1);
  assign sel_a_d    = bus.req_a[int'(win_id_q)*WIDTH +: WIDTH];
  assign sel_b_d    = bus.req_b[int'(win_id_q)*WIDTH +: WIDTH];
  assign sum_full_d = {1'b0, op_a_q} + {1'b0, op_b_q};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      win_id_q    <= '0;
      ptr_q       <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
      rsp_carry_q <= 1'b0;
      rsp_sovf_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_d) begin
            gnt_q    <= gnt_d;
            win_id_q <= win_d;
            state_q  <= GRANT;
          end
        end
        GRANT: begin
          gnt_q <= '0;
          // A withdrawn request aborts without touching the pointer.
          if (bus.req[win_id_q]) begin
            op_a_q  <= sel_a_d;
            op_b_q  <= sel_b_d;
            state_q <= EXEC;
          end else begin
            state_q <= IDLE;
          end
        end
        EXEC: begin
          rsp_sum_q   <= sum_full_d[WIDTH-1:0];
          rsp_carry_q <= sum_full_d[WIDTH];
          rsp_sovf_q  <= signed_ovf(op_a_q, op_b_q, sum_full_d[WIDTH-1:0]);
          rsp_id_q    <= win_id_q;
          rsp_valid_q <= 1'b1;
          ptr_q       <= ptr_d;
          state_q     <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            // Handshake is an arbitration point: chain straight into GRANT.
            if (any_d) begin
              gnt_q    <= gnt_d;
              win_id_q <= win_d;
              state_q  <= GRANT;
            end else begin
              state_q  <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_sum   = rsp_sum_q;
  assign bus.rsp_carry = rsp_carry_q;
  assign bus.rsp_sovf  = rsp_sovf_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Bench for adder_share_ctrl: directed scenarios plus a randomized phase,
// all checked every cycle against a transaction-age reference model.
module tb_adder_share_ctrl;

  localparam int NREQ  = 4;
  localparam int WIDTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  adder_share_ctrl_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  adder_share_ctrl #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Requester-side state
  bit want  [NREQ];
  int ra    [NREQ];
  int rb    [NREQ];
  bit gseen [NREQ];
  bit hold_all = 1'b0;

  // Reference model: age of the current transaction (-1 = none, 0 = grant
  // visible, 1 = adding, 2 = response outstanding)
  int m_age = -1, m_wid = 0, m_ptr = 0, m_a = 0, m_b = 0;
  int m_gnt = 0, m_valid = 0, m_id = 0, m_sum = 0, m_carry = 0, m_sovf = 0;

  int gorder[$];
  int gcyc[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      bus.req[i]                  = want[i];
      bus.req_a[i*WIDTH +: WIDTH] = WIDTH'(ra[i]);
      bus.req_b[i*WIDTH +: WIDTH] = WIDTH'(rb[i]);
    end
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++)
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  function automatic int to_signed(input int v);
    return (v >= (1 << (WIDTH - 1))) ? v - (1 << WIDTH) : v;
  endfunction

  task automatic model_step();
    logic [NREQ-1:0] r;
    int s;
    r = bus.req;
    if (!rst_n) begin
      m_age = -1; m_ptr = 0; m_wid = 0; m_valid = 0;
      m_id = 0; m_sum = 0; m_carry = 0; m_sovf = 0;
    end else begin
      case (m_age)
        -1: if (r != 0) begin m_wid = rr_pick(r, m_ptr); m_age = 0; end
        0: begin
          if (r[m_wid]) begin m_a = ra[m_wid]; m_b = rb[m_wid]; m_age = 1; end
          else m_age = -1;
        end
        1: begin
          m_sum   = (m_a + m_b) % (1 << WIDTH);
          m_carry = ((m_a + m_b) >= (1 << WIDTH)) ? 1 : 0;
          s       = to_signed(m_a) + to_signed(m_b);
          m_sovf  = (s > (1 << (WIDTH - 1)) - 1 || s < -(1 << (WIDTH - 1))) ? 1 : 0;
          m_id    = m_wid;
          m_valid = 1;
          m_ptr   = (m_wid + 1) % NREQ;
          m_age   = 2;
        end
        default: begin
          if (bus.rsp_ready) begin
            m_valid = 0;
            if (r != 0) begin m_wid = rr_pick(r, m_ptr); m_age = 0; end
            else m_age = -1;
          end
        end
      endcase
    end
    m_gnt = (m_age == 0) ? (1 << m_wid) : 0;
  endtask

  task automatic compare_all();
    chk("gnt", bus.gnt, m_gnt);
    chk("gnt_onehot0", $onehot0(bus.gnt), 1);
    chk("busy", bus.busy, (m_age != -1));
    chk("rsp_valid", bus.rsp_valid, m_valid);
    chk("rsp_id", bus.rsp_id, m_id);
    chk("rsp_sum", bus.rsp_sum, m_sum);
    chk("rsp_carry", bus.rsp_carry, m_carry);
    chk("rsp_sovf", bus.rsp_sovf, m_sovf);
  endtask

  // One clock: model sees the inputs the DUT is about to sample.
  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    compare_all();
    if (bus.gnt != 0) begin
      gorder.push_back($clog2(bus.gnt));
      gcyc.push_back(cyc);
    end
    for (int i = 0; i < NREQ; i++) begin
      if (gseen[i] && !hold_all) want[i] = 1'b0;
      gseen[i] = m_gnt[i];
    end
    drive();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < NREQ; i++) begin want[i] = 1'b0; gseen[i] = 1'b0; end
    drive();
    ticks(2);
    rst_n = 1'b1;
  endtask

  task automatic raise(input int i, input int a, input int b);
    want[i] = 1'b1; ra[i] = a; rb[i] = b;
    drive();
  endtask

  initial begin
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) begin ra[i] = 0; rb[i] = 0; end
    do_reset();
    chk("rst_busy", bus.busy, 0);
    chk("rst_valid", bus.rsp_valid, 0);

    // Basic latency and sum
    raise(0, 3, 4);
    tick(); chk("t1_gnt", bus.gnt, 4'b0001);
    tick(); chk("t1_novalid", bus.rsp_valid, 0);
    tick(); chk("t1_valid", bus.rsp_valid, 1);
    chk("t1_sum", bus.rsp_sum, 7); chk("t1_carry", bus.rsp_carry, 0);
    tick(); chk("t1_idle", bus.busy, 0);

    // Carry and signed overflow
    raise(1, 9, 8);
    ticks(3);
    chk("t2a_sum", bus.rsp_sum, 1); chk("t2a_carry", bus.rsp_carry, 1);
    chk("t2a_sovf", bus.rsp_sovf, 1); chk("t2a_id", bus.rsp_id, 1);
    tick();
    raise(1, 5, 4);
    ticks(3);
    chk("t2b_sum", bus.rsp_sum, 9); chk("t2b_carry", bus.rsp_carry, 0);
    chk("t2b_sovf", bus.rsp_sovf, 1);
    tick();

    // All four held: round-robin order and 3-cycle spacing
    do_reset();
    hold_all = 1'b1;
    for (int i = 0; i < NREQ; i++) raise(i, $urandom_range(0, 15), $urandom_range(0, 15));
    gorder.delete(); gcyc.delete();
    ticks(14);
    chk("t3_count", (gorder.size() >= 5), 1);
    if (gorder.size() >= 5) begin
      chk("t3_ord0", gorder[0], 0); chk("t3_ord1", gorder[1], 1);
      chk("t3_ord2", gorder[2], 2); chk("t3_ord3", gorder[3], 3);
      chk("t3_ord4", gorder[4], 0);
      for (int k = 1; k < 5; k++) chk("t3_gap", gcyc[k] - gcyc[k-1], 3);
    end
    hold_all = 1'b0;
    for (int i = 0; i < NREQ; i++) want[i] = 1'b0;
    drive();
    ticks(6);

    // Stalled response, then chained grant on handshake
    do_reset();
    bus.rsp_ready = 1'b0;
    raise(0, $urandom_range(0, 15), $urandom_range(0, 15));
    ticks(3);
    raise(2, 6, 7);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t4_busy", bus.busy, 1); chk("t4_nognt", bus.gnt, 0);
      chk("t4_hold", bus.rsp_valid, 1);
    end
    bus.rsp_ready = 1'b1;
    tick(); chk("t4_gnt", bus.gnt, 4'b0100);
    ticks(4);

    // Withdrawal during GRANT
    do_reset();
    raise(3, 2, 2);
    tick(); chk("t5_gnt", bus.gnt, 4'b1000);
    want[3] = 1'b0; drive();
    tick(); chk("t5_abort_busy", bus.busy, 0); chk("t5_abort_valid", bus.rsp_valid, 0);
    tick();
    raise(3, 1, 6);
    tick(); chk("t5_regnt", bus.gnt, 4'b1000);
    ticks(2); chk("t5_sum", bus.rsp_sum, 7);
    tick();

    // Reset during EXEC
    do_reset();
    raise(0, 7, 7);
    ticks(2);
    rst_n = 1'b0; drive();
    tick(); chk("t6_busy", bus.busy, 0); chk("t6_valid", bus.rsp_valid, 0);
    rst_n = 1'b1;
    ticks(2); chk("t6_noresp", bus.rsp_valid, 0);
    raise(0, 2, 3);
    tick(); chk("t6_gnt", bus.gnt, 4'b0001);
    ticks(2); chk("t6_valid2", bus.rsp_valid, 1); chk("t6_sum", bus.rsp_sum, 5);
    tick();

    // Randomized traffic, stalls, withdrawals and occasional resets
    for (int c = 0; c < 3000; c++) begin
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if (gseen[i] && $urandom_range(0, 7) == 0) want[i] = 1'b0;
        else if (!want[i] && !gseen[i] && $urandom_range(0, 3) == 0) begin
          want[i] = 1'b1;
          ra[i] = $urandom_range(0, 15);
          rb[i] = $urandom_range(0, 15);
        end
      end
      rst_n = ($urandom_range(0, 399) != 0);
      drive();
      tick();
    end
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
